booth_accum_seq: RTL

BOOTH_ACCUM_SEQ -- requirements
Module: booth_accum_seq

---
 rtl/booth_accum_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/booth_accum_seq.sv
// Sequential radix-4 Booth multiplier with accumulate-and-shift datapath.
// Handles signed and unsigned operands through one shared datapath.
module booth_accum_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   md,
    input  logic [N-1:0]   mr,
    input  logic           is_signed,
    output logic [2*N-1:0] res,
    output logic           busy,
    output logic           done
);

    localparam int E  = N + 2;
    localparam int AW = 2 * N + 4;
    localparam int CW = $clog2(N / 2 + 2);
    localparam logic [CW-1:0] LAST = CW'(N / 2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if ((N % 2) != 0 || N < 4 || N > 32) begin : g_bad_n
        $error("booth_accum_seq: N must be even and within 4..32");
    end

    logic [1:0]    state;
    logic [E-1:0]  md_ext;
    logic [AW-1:0] acc;
    logic          guard;
    logic [CW-1:0] cnt;

    logic          accept;
    logic [E-1:0]  md_in;
    logic [E-1:0]  mr_in;
    logic [2:0]    win;
    logic [E:0]    md_x;
    logic [E:0]    sel;
    logic          neg;
    logic [E:0]    addend;
    logic [E:0]    hi_x;
    logic [E:0]    sum;
    logic [AW-1:0] acc_nxt;
    logic          guard_nxt;

    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // Operand extension to N+2 bits: sign- or zero-extend by mode.
    always_comb begin
        md_in = {2'b00, md};
        mr_in = {2'b00, mr};
        if (is_signed) begin
            md_in = {{2{md[N-1]}}, md};
            mr_in = {{2{mr[N-1]}}, mr};
        end
    end

    // Booth recode of the low window, add to the upper part, shift by two.
    // The upper part is sign-extended one bit so the add never overflows.
    always_comb begin
        win    = {acc[1], acc[0], guard};
        md_x   = {md_ext[E-1], md_ext};
        sel    = '0;
        neg    = 1'b0;
        case (win)
            3'b001, 3'b010: sel = md_x;
            3'b011:         sel = md_x << 1;
            3'b100: begin
                sel = md_x << 1;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                sel = md_x;
                neg = 1'b1;
            end
            default:        sel = '0;
        endcase
        addend    = neg ? ~sel : sel;
        hi_x      = {acc[AW-1], acc[AW-1:E]};
        sum       = hi_x + addend + {{E{1'b0}}, neg};
        acc_nxt   = {sum[E], sum, acc[E-1:2]};
        guard_nxt = acc[1];
    end

    // FSM, iteration counter, accumulator and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            md_ext <= '0;
            acc    <= '0;
            guard  <= 1'b0;
            cnt    <= '0;
            res    <= '0;
        end else if (accept) begin
            state  <= RUN;
            md_ext <= md_in;
            acc    <= {{(AW-E){1'b0}}, mr_in};
            guard  <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            guard <= guard_nxt;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) begin
                state <= DONE;
                res   <= acc_nxt[2*N-1:0];
            end
        end else begin
            state <= IDLE;
        end
    end

endmodule
